// File: rtl/lsu_pkg.sv
// Shared load/store unit types: access-width codes, tag struct, FSM states and
// the load result extension helper used on the writeback path.
`ifndef LSU_DEFINES_SVH
`define LSU_DEFINES_SVH
`define DATAWIDTH_BYTE  2'b00
`define DATAWIDTH_SHORT 2'b01
`define DATAWIDTH_WORD  2'b10
`endif

package lsu_pkg;

   localparam logic [1:0] DATAWIDTH_BYTE  = `DATAWIDTH_BYTE;
   localparam logic [1:0] DATAWIDTH_SHORT = `DATAWIDTH_SHORT;
   localparam logic [1:0] DATAWIDTH_WORD  = `DATAWIDTH_WORD;

   typedef enum logic {
      READY,
      STORE_HOLD
   } lsu_state_e;

   typedef struct packed {
      logic       valid;
      logic [3:0] rd;
      logic [1:0] width;
      logic       zext;
   } lsu_tag_t;

   // Memory returns data already rotated so the addressed byte sits at bit 0.
   function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                               input logic [1:0]  width,
                                               input logic        zext);
      logic [31:0] result;
      result = raw;
      case (width)
         DATAWIDTH_BYTE:  result = zext ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
         DATAWIDTH_SHORT: result = zext ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
         default:         result = raw;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/lsu_tag_pipe.sv
// Delay line carrying load tags alongside the memory read latency; flush
// invalidates everything in flight but still admits the incoming tag.
module lsu_tag_pipe
   import lsu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     flush,
   input  lsu_tag_t in_tag,
   output lsu_tag_t out_tag
);

   lsu_tag_t stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= in_tag;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= flush ? '0 : stage[i-1];
         end
      end
   end

   assign out_tag = stage[DEPTH-1];

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: registers requests onto the memory group port, tracks load
// tags through the read latency and extends returned data for writeback.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter  int DATA_DEPTH   = 4096,
   parameter  int READ_LATENCY = 3,
   localparam int MAW          = 2 + $clog2(DATA_DEPTH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic           req_we,
   input  logic [1:0]     req_width,
   input  logic           req_unsigned,
   input  logic [31:0]    req_addr,
   input  logic [31:0]    req_wdata,
   input  logic [3:0]     req_rd,
   input  logic           flush,
   output logic           resp_valid,
   output logic [3:0]     resp_rd,
   output logic [31:0]    resp_data,
   output logic           fault,
   output logic           mem_we,
   output logic [1:0]     mem_data_width,
   output logic [MAW-1:0] mem_addr,
   output logic [31:0]    mem_write_data,
   input  logic [31:0]    mem_read_data
);

   lsu_state_e state;
   logic       mem_we_q;
   logic       req_illegal;
   logic       accept;
   logic       issue;
   lsu_tag_t   in_tag;
   lsu_tag_t   out_tag;

   assign req_illegal = (req_addr[31:MAW] != '0) || (req_width == 2'b11);
   assign req_ready   = (state == READY) && !rst;
   assign accept      = req_valid && req_ready;
   assign issue       = accept && !req_illegal;

   // Single-cycle STORE_HOLD stall lets the write land before any later load reads it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= READY;
         mem_we_q       <= 1'b0;
         fault          <= 1'b0;
         mem_addr       <= '0;
         mem_data_width <= '0;
         mem_write_data <= '0;
      end else begin
         mem_we_q <= issue && req_we;
         fault    <= accept && req_illegal;
         if (issue) begin
            mem_addr       <= req_addr[MAW-1:0];
            mem_data_width <= req_width;
            mem_write_data <= req_wdata;
         end
         case (state)
            READY:      state <= (issue && req_we) ? STORE_HOLD : READY;
            STORE_HOLD: state <= READY;
            default:    state <= READY;
         endcase
      end
   end

   // A reset arriving in the write cycle must still keep the memory untouched.
   assign mem_we = mem_we_q && !rst;

   always_comb begin
      in_tag       = '0;
      in_tag.valid = issue && !req_we;
      in_tag.rd    = req_rd;
      in_tag.width = req_width;
      in_tag.zext  = req_unsigned;
   end

   lsu_tag_pipe #(
      .DEPTH (READ_LATENCY + 1)
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .in_tag  (in_tag),
      .out_tag (out_tag)
   );

   assign resp_valid = out_tag.valid;
   assign resp_rd    = out_tag.valid ? out_tag.rd : 4'h0;
   assign resp_data  = out_tag.valid ? load_extend(mem_read_data, out_tag.width, out_tag.zext) : 32'h0;

endmodule
